// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared state encoding, register word indices and keyframe field layout
package rgb_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FADE = 2'd2, DONE = 2'd3} seq_state_t;
  localparam logic [4:0] CTRL_IDX = 5'd0;
  localparam logic [4:0] DIV_IDX = 5'd1;
  localparam logic [4:0] STATUS_IDX = 5'd2;
  localparam logic [4:0] KEY_BASE = 5'd16;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;
  function automatic int chan_lsb(input int c);
    return c == 0 ? R_LSB : c == 1 ? G_LSB : B_LSB;
  endfunction
endpackage

// File: rtl/rgb_seq_regs.sv
// rgb_seq_regs: Wishbone slave and control/keyframe register file
module rgb_seq_regs
  import rgb_seq_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [1:0]                 state,
  input  logic [3:0]                 key_idx,
  input  logic                       done_clr,
  output logic                       enable,
  output logic                       loop_en,
  output logic                       start,
  output logic [DIV_W-1:0]           step_div,
  output logic [NUM_KEYS-1:0][23:0]  keys
);
  localparam int KW = $clog2(NUM_KEYS);
  logic req, wr, key_hit, unused;
  logic [4:0] idx, key_off;
  logic [31:0] rdata;
  assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr = req & wbs_we_i;
  assign idx = wbs_adr_i[6:2];
  assign key_off = idx - KEY_BASE;
  assign key_hit = idx >= KEY_BASE && key_off < 5'(NUM_KEYS);
  assign unused = ^{wbs_adr_i[31:7], wbs_adr_i[1:0], wbs_dat_i[31:24]};
  assign rdata = idx == CTRL_IDX ? {30'd0, loop_en, enable}
               : idx == DIV_IDX ? 32'(step_div)
               : idx == STATUS_IDX ? {20'd0, key_idx, 6'd0, state}
               : key_hit ? {8'd0, keys[key_off[KW-1:0]]} : '0;
  // bus handshake and register writes; a CTRL write overrides the end-of-sequence enable clear
  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      enable <= 1'b0;
      loop_en <= 1'b0;
      start <= 1'b0;
      step_div <= DIV_W'(1);
      keys <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : '0;
      start <= wr && idx == CTRL_IDX && wbs_dat_i[0] && !enable;
      if (wr && idx == CTRL_IDX) {loop_en, enable} <= wbs_dat_i[1:0];
      else if (done_clr) enable <= 1'b0;
      if (wr && idx == DIV_IDX) step_div <= wbs_dat_i[DIV_W-1:0];
      if (wr && key_hit) keys[key_off[KW-1:0]] <= wbs_dat_i[23:0];
    end
  end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: keyframe RGB fader producing PWM duty levels
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  level0,
  output logic [7:0]  level1,
  output logic [7:0]  level2,
  output logic        seq_active,
  output logic        seq_done
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam logic [KW-1:0] LAST = KW'(NUM_KEYS - 1);
  seq_state_t state, state_nx;
  logic [KW-1:0] key_idx, key_idx_nx;
  logic [DIV_W-1:0] step_div, div_cnt, div_max;
  logic [NUM_KEYS-1:0][23:0] keys;
  logic [23:0] target;
  logic [2:0][7:0] lvl;
  logic [2:0] ch_eq;
  logic enable, loop_en, start, at_target, tick;
  rgb_seq_regs #(.NUM_KEYS(NUM_KEYS), .DIV_W(DIV_W)) u_regs (
    .clk(clk),
    .reset(reset),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .state(state),
    .key_idx(4'(key_idx)),
    .done_clr(state == DONE),
    .enable(enable),
    .loop_en(loop_en),
    .start(start),
    .step_div(step_div),
    .keys(keys)
  );
  assign div_max = step_div == '0 ? DIV_W'(1) : step_div;
  assign at_target = &ch_eq;
  assign tick = state == FADE && enable && !at_target
             && {1'b0, div_cnt} + (DIV_W+1)'(1) >= {1'b0, div_max};
  assign level0 = lvl[0];
  assign level1 = lvl[1];
  assign level2 = lvl[2];
  assign seq_active = state != IDLE;
  assign seq_done = state == DONE;
  // sequencing: start on enable edge, advance keyframes when all channels arrive, abort on enable clear
  always_comb begin
    state_nx = state;
    key_idx_nx = key_idx;
    case (state)
      IDLE: if (start) begin
        state_nx = LOAD;
        key_idx_nx = '0;
      end
      LOAD: state_nx = enable ? FADE : IDLE;
      FADE: if (!enable) state_nx = IDLE;
      else if (at_target) begin
        state_nx = key_idx != LAST || loop_en ? LOAD : DONE;
        key_idx_nx = key_idx != LAST ? key_idx + KW'(1) : loop_en ? '0 : key_idx;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, keyframe index, latched target and step divider
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      key_idx <= '0;
      target <= '0;
      div_cnt <= '0;
    end else begin
      state <= state_nx;
      key_idx <= key_idx_nx;
      if (state == LOAD) target <= keys[key_idx];
      div_cnt <= state == FADE && !tick ? div_cnt + DIV_W'(1) : '0;
    end
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam int LSB = chan_lsb(c);
    logic [7:0] v;
    assign ch_eq[c] = v == target[LSB +: 8];
    assign lvl[c] = v;
    // move this channel one LSB toward its target on each divider wrap
    always_ff @(posedge clk) begin
      if (reset) v <= '0;
      else if (tick && !ch_eq[c]) v <= v < target[LSB +: 8] ? v + 8'd1 : v - 8'd1;
    end
  end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: randomized self-checking bench against a keyframe timeline model
module tb_rgb_fade_sequencer;
  localparam int NK = 4;
  localparam int HZ = 400;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_DIV = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_KEY0 = 32'h40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0, rdat;
  logic ack, active, done;
  logic [7:0] l0, l1, l2;
  int checks = 0, fails = 0;
  logic [23:0] m_keys [NK];
  int m_div;
  logic [23:0] cur_lvl;
  logic [23:0] exp_lvl [0:HZ];
  int done_at;
  logic [31:0] q;

  always #5 clk = ~clk;

  rgb_fade_sequencer dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .level0(l0), .level1(l1), .level2(l2),
    .seq_active(active), .seq_done(done)
  );

  function automatic logic [23:0] step_toward(input logic [23:0] v, input logic [23:0] t);
    logic [23:0] r;
    int a, b;
    r = v;
    for (int i = 0; i < 3; i++) begin
      a = int'(v[8*i +: 8]);
      b = int'(t[8*i +: 8]);
      r[8*i +: 8] = 8'(a < b ? a + 1 : a > b ? a - 1 : a);
    end
    return r;
  endfunction

  // timeline model: sample k is taken just after the k-th clock edge following the enable-write ack
  task automatic build_model(input bit lp);
    int d, f, t, k;
    logic [23:0] v;
    d = m_div == 0 ? 1 : m_div;
    v = cur_lvl;
    done_at = -1;
    for (int i = 0; i <= HZ; i++) exp_lvl[i] = v;
    f = 2;
    k = 0;
    while (f <= HZ) begin
      t = f;
      while (v != m_keys[k]) begin
        t += d;
        v = step_toward(v, m_keys[k]);
        for (int i = t; i <= HZ; i++) exp_lvl[i] = v;
      end
      if (k == NK - 1 && !lp) begin
        done_at = t + 1;
        break;
      end
      k = (k + 1) % NK;
      f = t + 2;
    end
  endtask

  task automatic wb_cycle(input logic [31:0] a, input logic [31:0] d, input logic w, output logic [31:0] r);
    int n;
    n = 0;
    adr = a; dat = d; we = w; stb = 1'b1; cyc = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checks++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL wb_ack adr=%h: ack=%b after %0d clks, required 1", a, ack, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_cycle(a, d, 1'b1, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cur_lvl = '0;
  endtask

  task automatic set_keys(input logic [23:0] k0, k1, k2, k3, input int d);
    m_keys[0] = k0; m_keys[1] = k1; m_keys[2] = k2; m_keys[3] = k3;
    m_div = d;
    for (int i = 0; i < NK; i++) wb_write(A_KEY0 + 32'(4 * i), {8'd0, m_keys[i]});
    wb_write(A_DIV, 32'(d));
  endtask

  task automatic start_seq(input bit lp);
    logic [31:0] r;
    build_model(lp);
    adr = A_CTRL; dat = lp ? 32'd3 : 32'd1; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    r = rdat;
    checks++;
    if (ack !== 1'b1 || {l0, l1, l2} !== exp_lvl[0] || active !== 1'b0) begin
      fails++;
      $display("FAIL start: ack=%b levels=%h active=%b, required ack=1 levels=%h active=0 (rd %h)",
               ack, {l0, l1, l2}, active, exp_lvl[0], r);
    end
  endtask

  task automatic run_seq(input int n, input int wr_at, input logic [31:0] wa, input logic [31:0] wd, input bit abort);
    logic [23:0] e;
    bit ea, ed, cut;
    cut = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      cut = abort && k > wr_at + 1;
      e = cut ? exp_lvl[wr_at + 1] : exp_lvl[k];
      ea = !cut && (done_at < 0 || k <= done_at);
      ed = !cut && k == done_at;
      checks++;
      if ({l0, l1, l2} !== e || active !== ea || done !== ed) begin
        fails++;
        $display("FAIL seq k=%0d: levels=%h active=%b done=%b, required levels=%h active=%b done=%b",
                 k, {l0, l1, l2}, active, done, e, ea, ed);
      end
      if (k == wr_at + 1) begin
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++;
        if (ack !== 1'b1) begin
          fails++;
          $display("FAIL midseq_ack k=%0d: ack=%b, required 1", k, ack);
        end
      end
      if (k == wr_at) begin
        adr = wa; dat = wd; we = 1'b1; stb = 1'b1; cyc = 1'b1;
      end
    end
    cur_lvl = abort ? exp_lvl[wr_at + 1] : exp_lvl[n];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cur_lvl = '0;
    checks++;
    if ({l0, l1, l2} !== 24'h0) begin fails++; $display("FAIL reset_levels: %h, required 000000", {l0, l1, l2}); end
    checks++;
    if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: %b, required 0", ack); end
    checks++;
    if (active !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_flags: active=%b done=%b, required 0 0", active, done); end
    wb_cycle(A_STATUS, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL reset_status: %h, required 0", q); end
    wb_cycle(A_DIV, 0, 1'b0, q);
    checks++;
    if (q !== 32'h1) begin fails++; $display("FAIL reset_stepdiv: %h, required 1", q); end
    wb_cycle(A_CTRL, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL reset_ctrl: %h, required 0", q); end
  endtask

  task automatic test_single_ramp();
    do_reset();
    set_keys(24'h030000, 24'h0, 24'h0, 24'h0, 2);
    start_seq(1'b0);
    run_seq(done_at + 3, -1, 0, 0, 1'b0);
    wb_cycle(A_CTRL, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL ramp_ctrl_cleared: %h, required 0", q); end
    wb_cycle(A_STATUS, 0, 1'b0, q);
    checks++;
    if (q !== 32'h300) begin fails++; $display("FAIL ramp_status: %h, required 300", q); end
  endtask

  task automatic test_loop();
    do_reset();
    set_keys(24'h000002, 24'h0, 24'h0, 24'h0, 1);
    start_seq(1'b1);
    run_seq(120, 100, A_CTRL, 32'h0, 1'b1);
    wb_cycle(A_CTRL, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL loop_ctrl: %h, required 0", q); end
  endtask

  task automatic test_abort();
    do_reset();
    set_keys(24'h0c0c0c, 24'h050505, 24'h0, 24'h0, 2);
    start_seq(1'b0);
    run_seq(30, 10, A_CTRL, 32'h0, 1'b1);
    wb_cycle(A_STATUS, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL abort_status: %h, required 0", q); end
  endtask

  task automatic test_identical();
    do_reset();
    set_keys(24'h101010, 24'h101010, 24'h101010, 24'h101010, 0);
    start_seq(1'b0);
    run_seq(done_at + 3, -1, 0, 0, 1'b0);
  endtask

  task automatic test_key_write();
    do_reset();
    set_keys(24'h200000, 24'h0, 24'h0, 24'h0, 1);
    start_seq(1'b0);
    run_seq(done_at + 3, 5, A_KEY0, 32'h050000, 1'b0);
    wb_cycle(A_KEY0, 0, 1'b0, q);
    checks++;
    if (q !== 32'h050000) begin fails++; $display("FAIL key_readback: %h, required 050000", q); end
  endtask

  task automatic test_bus();
    wb_cycle(32'h14, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL unmapped_5: %h, required 0", q); end
    wb_write(32'h14, 32'hdeadbeef);
    wb_cycle(32'h14, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL unmapped_5_write: %h, required 0", q); end
    wb_cycle(32'h50, 0, 1'b0, q);
    checks++;
    if (q !== 32'h0) begin fails++; $display("FAIL unmapped_key4: %h, required 0", q); end
    adr = A_CTRL; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== (i != 1)) begin fails++; $display("FAIL b2b_ack[%0d]: %b, required %b", i, ack, i != 1); end
    end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      set_keys({8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))},
               {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))},
               {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))},
               {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))},
               int'($urandom_range(0, 3)));
      start_seq(1'b0);
      run_seq(done_at + 3, -1, 0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_ramp();
    test_loop();
    test_abort();
    test_random();
    test_identical();
    test_key_write();
    test_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
